// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline stage.
//  - WB_REGWRITE / WB_MEMTOREG : bit positions inside the write-back control field
//  - *_DEF                     : default datapath widths of the stage
//  - stage_t                   : stage payload {wb, rd, mem, alu} at the default widths.
//                                Modules with other widths declare the same layout
//                                locally from their own parameters.
//  - payload_w()               : packed width of a payload for arbitrary widths
package pipe_pkg;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;
    localparam int WB_W_DEF = 2;

    typedef struct packed {
        logic [WB_W_DEF-1:0] wb;
        logic [RD_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0] mem;
        logic [XLEN_DEF-1:0] alu;
    } stage_t;

    function automatic int payload_w(input int xlen, input int rd_w, input int wb_w);
        return wb_w + rd_w + 2 * xlen;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// Bus bundle of the MEM->WB stage.
//  Upstream side : flush, in_valid, in_ready, wb_in, rd_in, mem_in, alu_in
//  Downstream    : out_ready, out_valid, wb_out, rd_out, wr_en, wr_addr, wr_data,
//                  fwd_valid, retired
//  modport slave  : view of the pipeline stage itself
//  modport master : view of the surrounding pipeline / register file
interface mem_wb_pipe_if #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int WB_W  = 2,
    parameter int CNT_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [WB_W-1:0] wb_in;
    logic [RD_W-1:0] rd_in;
    logic [XLEN-1:0] mem_in;
    logic [XLEN-1:0] alu_in;
    logic            out_ready;
    logic            out_valid;
    logic [WB_W-1:0] wb_out;
    logic [RD_W-1:0] rd_out;
    logic            wr_en;
    logic [RD_W-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            fwd_valid;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  flush, in_valid, wb_in, rd_in, mem_in, alu_in, out_ready,
        output in_ready, out_valid, wb_out, rd_out, wr_en, wr_addr, wr_data,
               fwd_valid, retired
    );

    modport master (
        output flush, in_valid, wb_in, rd_in, mem_in, alu_in, out_ready,
        input  in_ready, out_valid, wb_out, rd_out, wr_en, wr_addr, wr_data,
               fwd_valid, retired
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready skid buffer on a packed payload.
//  clk, rst         : clock, synchronous active-high reset
//  i_flush          : drop both entries and any incoming beat
//  i_in_valid/o_in_ready/i_in_data    : upstream handshake
//  o_out_valid/i_out_ready/o_out_data : downstream handshake (head entry)
// The head register feeds the output; the skid register catches a beat accepted
// while the head is stalled. o_in_ready depends only on the skid valid flop, so
// there is no combinational path from i_out_ready back to upstream.
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);
    logic         r_h_valid;
    logic         r_s_valid;
    logic [W-1:0] r_h_data;
    logic [W-1:0] r_s_data;

    logic w_accept;
    logic w_h_load;

    assign w_accept = i_in_valid & ~r_s_valid;
    // Head may take a new beat when empty or when its beat leaves this cycle.
    assign w_h_load = ~r_h_valid | (r_h_valid & i_out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_h_data  <= '0;
            r_s_data  <= '0;
        end else if (i_flush) begin
            r_h_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_h_load) begin
            if (r_s_valid) begin
                // Older skid beat goes first; upstream is stalled (in_ready=0).
                r_h_data  <= r_s_data;
                r_h_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else begin
                r_h_valid <= w_accept;
                if (w_accept) begin
                    r_h_data <= i_in_data;
                end
            end
        end else if (w_accept) begin
            r_s_data  <= i_in_data;
            r_s_valid <= 1'b1;
        end
    end

    assign o_in_ready  = ~r_s_valid;
    assign o_out_valid = r_h_valid;
    assign o_out_data  = r_h_data;
endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with handshake, skid buffer, flush, write-back mux,
// register-file write outputs, forwarding tap and retired-write counter.
//  clk, rst : clock, synchronous active-high reset
//  bus      : mem_wb_pipe_if slave (upstream beat, downstream regfile port)
module mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int WB_W  = 2,
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_pipe_if.slave   bus
);
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] mem;
        logic [XLEN-1:0] alu;
    } payload_t;

    localparam int PW = payload_w(XLEN, RD_W, WB_W);

    payload_t         w_in_pl;
    payload_t         w_head_pl;
    logic [PW-1:0]    w_head_bits;
    logic             w_out_valid;
    logic             w_rd_nz;
    logic             w_wr_en;
    logic [CNT_W-1:0] r_retired;

    assign w_in_pl = '{wb: bus.wb_in, rd: bus.rd_in, mem: bus.mem_in, alu: bus.alu_in};

    pipe_skid_reg #(.W(PW)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.flush),
        .i_in_valid  (bus.in_valid),
        .o_in_ready  (bus.in_ready),
        .i_in_data   (w_in_pl),
        .o_out_valid (w_out_valid),
        .i_out_ready (bus.out_ready),
        .o_out_data  (w_head_bits)
    );

    assign w_head_pl = payload_t'(w_head_bits);
    assign w_rd_nz   = (w_head_pl.rd != '0);

    // r0 is hard-wired zero, so writes to it never commit. A flush or reset
    // cycle commits nothing even if the head beat is being popped.
    assign w_wr_en = w_out_valid & bus.out_ready & ~bus.flush & ~rst
                   & w_head_pl.wb[WB_REGWRITE] & w_rd_nz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_wr_en) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.wb_out    = w_head_pl.wb;
    assign bus.rd_out    = w_head_pl.rd;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_addr   = w_head_pl.rd;
    assign bus.wr_data   = w_head_pl.wb[WB_MEMTOREG] ? w_head_pl.mem : w_head_pl.alu;
    assign bus.fwd_valid = w_out_valid & w_head_pl.wb[WB_REGWRITE] & w_rd_nz;
    assign bus.retired   = r_retired;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (CNT_W=4 so counter wrap is reachable).
// The reference model is an ordered queue of accepted beats (at most 2 held);
// the monitor compares the head of that queue with the DUT outputs every cycle.
module tb_mem_wb_pipe;
    localparam int XLEN  = 32;
    localparam int RD_W  = 5;
    localparam int WB_W  = 2;
    localparam int CNT_W = 4;

    typedef struct {
        logic [1:0]  wb;
        logic [4:0]  rd;
        logic [31:0] mem;
        logic [31:0] alu;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests = 0;
    int fails = 0;
    int exp_ret = 0;

    beat_t q[$];
    beat_t mon_h;
    bit    mon_we;

    mem_wb_pipe_if #(.XLEN(XLEN), .RD_W(RD_W), .WB_W(WB_W), .CNT_W(CNT_W)) bus ();

    mem_wb_pipe #(.XLEN(XLEN), .RD_W(RD_W), .WB_W(WB_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.wb_in     = '0;
        bus.rd_in     = '0;
        bus.mem_in    = '0;
        bus.alu_in    = '0;
        bus.out_ready = 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [1:0] wb, input logic [4:0] rd,
                                 input logic [31:0] mem, input logic [31:0] alu);
        beat_t b;
        b.wb = wb; b.rd = rd; b.mem = mem; b.alu = alu;
        return b;
    endfunction

    // Monitor: compares DUT against the model queue, then retires the head.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_wr_en", bus.wr_en, 0);
            q.delete();
            exp_ret = 0;
        end else begin
            check("out_valid", bus.out_valid, q.size() > 0);
            check("in_ready", bus.in_ready, q.size() < 2);
            check("retired", bus.retired, exp_ret);
            if (q.size() > 0) begin
                mon_h  = q[0];
                mon_we = bus.out_ready && !bus.flush && mon_h.wb[0] && (mon_h.rd != 0);
                check("wr_data", bus.wr_data, mon_h.wb[1] ? mon_h.mem : mon_h.alu);
                check("wr_addr", bus.wr_addr, mon_h.rd);
                check("rd_out", bus.rd_out, mon_h.rd);
                check("wb_out", bus.wb_out, mon_h.wb);
                check("fwd_valid", bus.fwd_valid, mon_h.wb[0] && (mon_h.rd != 0));
                check("wr_en", bus.wr_en, mon_we);
                $display("[TB] head rd=%0d wb=%0b data=0x%0h wr_en=%0b", mon_h.rd, mon_h.wb,
                         bus.wr_data, bus.wr_en);
                if (bus.out_ready && !bus.flush) void'(q.pop_front());
                if (mon_we) exp_ret = (exp_ret + 1) % 16;
            end else begin
                check("idle_wr_en", bus.wr_en, 0);
                check("idle_fwd", bus.fwd_valid, 0);
            end
            if (bus.flush) q.delete();
        end
    end

    // One cycle of stimulus; records an accepted beat in the model.
    task automatic tick(input bit v, input beat_t b, input bit ordy, input bit fl, output bit acc);
        @(posedge clk); #1;
        bus.in_valid  = v;
        bus.wb_in     = b.wb;
        bus.rd_in     = b.rd;
        bus.mem_in    = b.mem;
        bus.alu_in    = b.alu;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clk); #1;
        acc = v && (bus.in_ready === 1'b1) && !fl && !rst;
        if (acc) q.push_back(b);
    endtask

    task automatic send(input beat_t b, input int mode);
        bit acc;
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, b, (mode == 2) ? 1'($urandom % 2) : 1'(mode), 1'b0, acc);
            if (acc) return;
        end
        tests++; fails++;
        $display("FAIL send_timeout: beat rd=%0d not accepted within 64 cycles", b.rd);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, mk(0, 0, 0, 0), ordy, 1'b0, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 16 && q.size() > 0; i++) tick(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0, acc);
        check("drain_empty", q.size(), 0);
        tick(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0, acc);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        beat_t b;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_wr_en", bus.wr_en, 0);
        check("reset_retired", bus.retired, 0);
        check("reset_in_ready", bus.in_ready, 1);

        // Stream of 4 beats at full throughput
        for (int i = 0; i < 4; i++) send(mk(2'b01, 5'(i + 1), 32'h0, 32'h10 + 32'(i)), 1);
        drain();
        check("stream_retired", bus.retired, 4);

        // Write-back mux and r0 suppression
        send(mk(2'b11, 5'd7, 32'hDEAD, 32'hBEEF), 1);
        send(mk(2'b11, 5'd0, 32'hDEAD, 32'hBEEF), 1);
        drain();
        check("mux_retired", bus.retired, 5);

        // Backpressure: two beats fill H and S, third waits upstream
        send(mk(2'b01, 5'd9, 0, 32'h90), 0);
        send(mk(2'b01, 5'd10, 0, 32'hA0), 0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, mk(2'b01, 5'd11, 0, 32'hB0), 1'b0, 1'b0, acc);
            check("bp_third_held", acc, 0);
        end
        send(mk(2'b01, 5'd11, 0, 32'hB0), 1);
        drain();
        check("bp_retired", bus.retired, 8);

        // Flush with both entries full and a beat offered
        send(mk(2'b01, 5'd12, 0, 32'hC0), 0);
        send(mk(2'b01, 5'd13, 0, 32'hD0), 0);
        tick(1'b1, mk(2'b01, 5'd14, 0, 32'hE0), 1'b1, 1'b1, acc);
        @(negedge clk); #1;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        idle(3, 1'b1);
        check("flush_retired", bus.retired, 8);

        // Randomized traffic with flushes and a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            b = mk(2'($urandom), ($urandom % 4 == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
            tick(($urandom % 4) != 0, b, 1'($urandom % 2), ($urandom % 40) == 0, acc);
            if (i == 200) do_reset();
        end
        drain();

        // Counter wrap: 17 writes on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) send(mk(2'b01, 5'(1 + i % 31), 0, 32'(i)), 2);
        drain();
        check("wrap_retired", bus.retired, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
